// File: rtl/alu_rs_scheduler_pkg.sv
// Shared widths and ALU opcode encoding for the integer ALU
// reservation station, its interface and its testbench.
package alu_rs_scheduler_pkg;

   localparam int RS_DEPTH = 8;
   localparam int TAG_W    = 4;
   localparam int OP_W     = 6;
   localparam int XLEN     = 32;

   localparam logic [OP_W-1:0] OP_LUI   = 6'd0;
   localparam logic [OP_W-1:0] OP_AUIPC = 6'd1;
   localparam logic [OP_W-1:0] OP_JAL   = 6'd2;
   localparam logic [OP_W-1:0] OP_JALR  = 6'd3;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
   localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
   localparam logic [OP_W-1:0] OP_BLT   = 6'd6;
   localparam logic [OP_W-1:0] OP_BGE   = 6'd7;
   localparam logic [OP_W-1:0] OP_BLTU  = 6'd8;
   localparam logic [OP_W-1:0] OP_BGEU  = 6'd9;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'd10;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'd11;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'd12;
   localparam logic [OP_W-1:0] OP_XORI  = 6'd13;
   localparam logic [OP_W-1:0] OP_ORI   = 6'd14;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'd15;
   localparam logic [OP_W-1:0] OP_SLLI  = 6'd16;
   localparam logic [OP_W-1:0] OP_SRLI  = 6'd17;
   localparam logic [OP_W-1:0] OP_SRAI  = 6'd18;
   localparam logic [OP_W-1:0] OP_ADD   = 6'd19;
   localparam logic [OP_W-1:0] OP_SUB   = 6'd20;
   localparam logic [OP_W-1:0] OP_SLL   = 6'd21;
   localparam logic [OP_W-1:0] OP_SLT   = 6'd22;
   localparam logic [OP_W-1:0] OP_SLTU  = 6'd23;
   localparam logic [OP_W-1:0] OP_XOR   = 6'd24;
   localparam logic [OP_W-1:0] OP_SRL   = 6'd25;
   localparam logic [OP_W-1:0] OP_SRA   = 6'd26;
   localparam logic [OP_W-1:0] OP_OR    = 6'd27;
   localparam logic [OP_W-1:0] OP_AND   = 6'd28;

endpackage

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch / CDB / issue bundle of the ALU reservation station.
// master: dispatch+CDB+ALU side; slave: the station itself.
interface alu_rs_scheduler_if #(
   parameter int TAG_W = alu_rs_scheduler_pkg::TAG_W,
   parameter int OP_W  = alu_rs_scheduler_pkg::OP_W,
   parameter int XLEN  = alu_rs_scheduler_pkg::XLEN
);
   logic             flush;
   logic             alloc_valid;
   logic             alloc_ready;
   logic [OP_W-1:0]  alloc_op;
   logic [TAG_W-1:0] alloc_rob_tag;
   logic             alloc_q1_busy;
   logic [TAG_W-1:0] alloc_q1_tag;
   logic [XLEN-1:0]  alloc_v1;
   logic             alloc_q2_busy;
   logic [TAG_W-1:0] alloc_q2_tag;
   logic [XLEN-1:0]  alloc_v2;
   logic [XLEN-1:0]  alloc_imm;
   logic [XLEN-1:0]  alloc_pc;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_data;
   logic             issue_valid;
   logic [OP_W-1:0]  issue_op;
   logic [XLEN-1:0]  issue_v1;
   logic [XLEN-1:0]  issue_v2;
   logic [XLEN-1:0]  issue_imm;
   logic [XLEN-1:0]  issue_pc;
   logic [TAG_W-1:0] issue_rob_tag;

   modport master (
      output flush, alloc_valid, alloc_op, alloc_rob_tag,
      output alloc_q1_busy, alloc_q1_tag, alloc_v1,
      output alloc_q2_busy, alloc_q2_tag, alloc_v2,
      output alloc_imm, alloc_pc,
      output cdb_valid, cdb_tag, cdb_data,
      input  alloc_ready, issue_valid, issue_op,
      input  issue_v1, issue_v2, issue_imm, issue_pc,
      input  issue_rob_tag
   );

   modport slave (
      input  flush, alloc_valid, alloc_op, alloc_rob_tag,
      input  alloc_q1_busy, alloc_q1_tag, alloc_v1,
      input  alloc_q2_busy, alloc_q2_tag, alloc_v2,
      input  alloc_imm, alloc_pc,
      input  cdb_valid, cdb_tag, cdb_data,
      output alloc_ready, issue_valid, issue_op,
      output issue_v1, issue_v2, issue_imm, issue_pc,
      output issue_rob_tag
   );
endinterface

// File: rtl/alu_rs_scheduler_rs_age_select.sv
// Oldest-ready picker: ready vector + age matrix in, one-hot grant out.
// older[i][j]=1 means entry i was allocated before entry j.
module rs_age_select #(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0]            ready,
   input  logic [DEPTH-1:0][DEPTH-1:0] older,
   output logic [DEPTH-1:0]            grant,
   output logic                        any_grant
);
   always_comb begin
      grant = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = ready[i];
         // lose to any ready entry that is older than us
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && ready[j] && older[j][i]) begin
               grant[i] = 1'b0;
            end
         end
      end
   end

   assign any_grant = |grant;
endmodule

// File: rtl/alu_rs_scheduler.sv
// Integer ALU reservation station: holds dispatched ops until both
// operands are captured, then issues the oldest ready op each cycle.
// Ports: clk, rst (async, active-high), bus (alu_rs_scheduler_if.slave).
module alu_rs_scheduler #(
   parameter int DEPTH = alu_rs_scheduler_pkg::RS_DEPTH,
   parameter int TAG_W = alu_rs_scheduler_pkg::TAG_W,
   parameter int OP_W  = alu_rs_scheduler_pkg::OP_W,
   parameter int XLEN  = alu_rs_scheduler_pkg::XLEN
) (
   input logic clk,
   input logic rst,
   alu_rs_scheduler_if.slave bus
);
   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0]            busy;
   logic [DEPTH-1:0]            q1_busy;
   logic [DEPTH-1:0]            q2_busy;
   logic [OP_W-1:0]             op_q   [DEPTH];
   logic [TAG_W-1:0]            tag_q  [DEPTH];
   logic [TAG_W-1:0]            q1_tag [DEPTH];
   logic [TAG_W-1:0]            q2_tag [DEPTH];
   logic [XLEN-1:0]             v1_q   [DEPTH];
   logic [XLEN-1:0]             v2_q   [DEPTH];
   logic [XLEN-1:0]             imm_q  [DEPTH];
   logic [XLEN-1:0]             pc_q   [DEPTH];
   logic [DEPTH-1:0][DEPTH-1:0] older;

   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] grant;
   logic             any_grant;
   logic [IW-1:0]    free_idx;
   logic [IW-1:0]    gnt_idx;
   logic             alloc_fire;
   logic             hit1;
   logic             hit2;
   logic [XLEN-1:0]  a_v1;
   logic [XLEN-1:0]  a_v2;

   assign ready           = busy & ~q1_busy & ~q2_busy;
   assign bus.alloc_ready = ~&busy;
   assign alloc_fire      = bus.alloc_valid & bus.alloc_ready;

   // same-cycle CDB bypass into the entry being allocated
   assign hit1 = bus.cdb_valid & bus.alloc_q1_busy
               & (bus.alloc_q1_tag == bus.cdb_tag);
   assign hit2 = bus.cdb_valid & bus.alloc_q2_busy
               & (bus.alloc_q2_tag == bus.cdb_tag);
   assign a_v1 = hit1 ? bus.cdb_data : bus.alloc_v1;
   assign a_v2 = hit2 ? bus.cdb_data : bus.alloc_v2;

   rs_age_select #(.DEPTH(DEPTH)) u_sel (
      .ready     (ready),
      .older     (older),
      .grant     (grant),
      .any_grant (any_grant)
   );

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) free_idx = IW'(i);
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) gnt_idx = IW'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy              <= '0;
         q1_busy           <= '0;
         q2_busy           <= '0;
         older             <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= '0;
            tag_q[i]  <= '0;
            q1_tag[i] <= '0;
            q2_tag[i] <= '0;
            v1_q[i]   <= '0;
            v2_q[i]   <= '0;
            imm_q[i]  <= '0;
            pc_q[i]   <= '0;
         end
         bus.issue_valid   <= 1'b0;
         bus.issue_op      <= '0;
         bus.issue_v1      <= '0;
         bus.issue_v2      <= '0;
         bus.issue_imm     <= '0;
         bus.issue_pc      <= '0;
         bus.issue_rob_tag <= '0;
      end else if (bus.flush) begin
         busy            <= '0;
         bus.issue_valid <= 1'b0;
      end else begin
         bus.issue_valid <= any_grant;
         if (any_grant) begin
            bus.issue_op      <= op_q[gnt_idx];
            bus.issue_v1      <= v1_q[gnt_idx];
            bus.issue_v2      <= v2_q[gnt_idx];
            bus.issue_imm     <= imm_q[gnt_idx];
            bus.issue_pc      <= pc_q[gnt_idx];
            bus.issue_rob_tag <= tag_q[gnt_idx];
            busy[gnt_idx]     <= 1'b0;
         end
         if (bus.cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (busy[i] && q1_busy[i] && q1_tag[i] == bus.cdb_tag) begin
                  v1_q[i]    <= bus.cdb_data;
                  q1_busy[i] <= 1'b0;
               end
               if (busy[i] && q2_busy[i] && q2_tag[i] == bus.cdb_tag) begin
                  v2_q[i]    <= bus.cdb_data;
                  q2_busy[i] <= 1'b0;
               end
            end
         end
         // the free entry is never busy, so it cannot collide with
         // the granted entry or with a CDB capture above
         if (alloc_fire) begin
            busy[free_idx]    <= 1'b1;
            op_q[free_idx]    <= bus.alloc_op;
            tag_q[free_idx]   <= bus.alloc_rob_tag;
            q1_busy[free_idx] <= bus.alloc_q1_busy & ~hit1;
            q1_tag[free_idx]  <= bus.alloc_q1_tag;
            v1_q[free_idx]    <= a_v1;
            q2_busy[free_idx] <= bus.alloc_q2_busy & ~hit2;
            q2_tag[free_idx]  <= bus.alloc_q2_tag;
            v2_q[free_idx]    <= a_v2;
            imm_q[free_idx]   <= bus.alloc_imm;
            pc_q[free_idx]    <= bus.alloc_pc;
            // new entry is younger than every busy one
            for (int j = 0; j < DEPTH; j++) begin
               older[free_idx][j] <= 1'b0;
               older[j][free_idx] <= busy[j];
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed self-checking bench for alu_rs_scheduler with an
// in-order scoreboard of expected issue records.
module tb_alu_rs_scheduler;
   import alu_rs_scheduler_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   logic [159:0] sb [$];

   alu_rs_scheduler_if bus ();

   alu_rs_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [159:0] rec(
      input logic [OP_W-1:0]  op,
      input logic [XLEN-1:0]  v1,
      input logic [XLEN-1:0]  v2,
      input logic [XLEN-1:0]  imm,
      input logic [XLEN-1:0]  pc,
      input logic [TAG_W-1:0] tag
   );
      return {22'd0, op, v1, v2, imm, pc, tag};
   endfunction

   task automatic chk(input string tag, input logic [159:0] obs,
                      input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic alloc_set(
      input logic [OP_W-1:0]  op,
      input logic [TAG_W-1:0] tag,
      input logic             q1b,
      input logic [TAG_W-1:0] q1t,
      input logic [XLEN-1:0]  v1,
      input logic             q2b,
      input logic [TAG_W-1:0] q2t,
      input logic [XLEN-1:0]  v2,
      input logic [XLEN-1:0]  imm,
      input logic [XLEN-1:0]  pc
   );
      bus.alloc_valid   = 1'b1;
      bus.alloc_op      = op;
      bus.alloc_rob_tag = tag;
      bus.alloc_q1_busy = q1b;
      bus.alloc_q1_tag  = q1t;
      bus.alloc_v1      = v1;
      bus.alloc_q2_busy = q2b;
      bus.alloc_q2_tag  = q2t;
      bus.alloc_v2      = v2;
      bus.alloc_imm     = imm;
      bus.alloc_pc      = pc;
   endtask

   task automatic alloc_clr();
      bus.alloc_valid   = 1'b0;
      bus.alloc_q1_busy = 1'b0;
      bus.alloc_q2_busy = 1'b0;
   endtask

   task automatic cdb_set(input logic [TAG_W-1:0] t,
                          input logic [XLEN-1:0] d);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = t;
      bus.cdb_data  = d;
   endtask

   task automatic cdb_clr();
      bus.cdb_valid = 1'b0;
   endtask

   // monitor: every issue pulse must match the next expected record
   always @(negedge clk) begin
      if (!rst && bus.issue_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL unexpected_issue observed tag=%0h required none",
                   bus.issue_rob_tag);
         end else begin
            chk("issue_rec",
                rec(bus.issue_op, bus.issue_v1, bus.issue_v2,
                    bus.issue_imm, bus.issue_pc, bus.issue_rob_tag),
                sb.pop_front());
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      bus.flush = 1'b0;
      bus.alloc_op = '0;
      bus.alloc_rob_tag = '0;
      bus.alloc_q1_tag = '0;
      bus.alloc_v1 = '0;
      bus.alloc_q2_tag = '0;
      bus.alloc_v2 = '0;
      bus.alloc_imm = '0;
      bus.alloc_pc = '0;
      bus.cdb_tag = '0;
      bus.cdb_data = '0;
      alloc_clr();
      cdb_clr();
      #2 rst = 1'b1;
      cyc();
      cyc();
      chk("rst_valid", bus.issue_valid, 1'b0);
      chk("rst_op", bus.issue_op, '0);
      chk("rst_v1", bus.issue_v1, '0);
      chk("rst_tag", bus.issue_rob_tag, '0);
      chk("rst_ardy", bus.alloc_ready, 1'b1);
      rst = 1'b0;
      cyc();

      // 1: ready ADD issues after two edges
      sb.push_back(rec(OP_ADD, 5, 7, 32'h11, 32'h100, 4'd3));
      alloc_set(OP_ADD, 4'd3, 0, 0, 5, 0, 0, 7, 32'h11, 32'h100);
      cyc();
      alloc_clr();
      chk("t1_lat", bus.issue_valid, 1'b0);
      chk("t1_ardy", bus.alloc_ready, 1'b1);
      cyc();
      chk("t1_issue", bus.issue_valid, 1'b1);
      chk("t1_ardy2", bus.alloc_ready, 1'b1);
      cyc();
      chk("t1_pulse", bus.issue_valid, 1'b0);

      // 2: SUB waits for tag 9
      sb.push_back(rec(OP_SUB, 32'h10, 3, 32'h22, 32'h104, 4'd2));
      alloc_set(OP_SUB, 4'd2, 1, 4'd9, 32'hDEAD, 0, 0, 3, 32'h22, 32'h104);
      cyc();
      alloc_clr();
      chk("t2_wait0", bus.issue_valid, 1'b0);
      cyc();
      chk("t2_wait1", bus.issue_valid, 1'b0);
      cdb_set(4'd9, 32'h10);
      cyc();
      cdb_clr();
      chk("t2_wake", bus.issue_valid, 1'b0);
      cyc();
      chk("t2_issue", bus.issue_valid, 1'b1);
      cyc();

      // 3a: A waits, B and C ready -> B, C, A
      sb.push_back(rec(OP_XOR, 2, 3, 0, 32'h204, 4'hB));
      sb.push_back(rec(OP_OR, 4, 5, 0, 32'h208, 4'hC));
      sb.push_back(rec(OP_AND, 32'h55, 1, 0, 32'h200, 4'hA));
      alloc_set(OP_AND, 4'hA, 1, 4'd5, 0, 0, 0, 1, 0, 32'h200);
      cyc();
      alloc_set(OP_XOR, 4'hB, 0, 0, 2, 0, 0, 3, 0, 32'h204);
      cyc();
      alloc_set(OP_OR, 4'hC, 0, 0, 4, 0, 0, 5, 0, 32'h208);
      cyc();
      alloc_clr();
      chk("t3_b", bus.issue_valid, 1'b1);
      cyc();
      chk("t3_c", bus.issue_valid, 1'b1);
      cdb_set(4'd5, 32'h55);
      cyc();
      cdb_clr();
      chk("t3_gap", bus.issue_valid, 1'b0);
      cyc();
      chk("t3_a", bus.issue_valid, 1'b1);
      cyc();
      chk("t3_idle", bus.issue_valid, 1'b0);

      // 3b: A and C ready together -> older A first
      sb.push_back(rec(OP_SLT, 32'h77, 6, 0, 32'h300, 4'd1));
      sb.push_back(rec(OP_SLTU, 8, 9, 0, 32'h304, 4'd4));
      alloc_set(OP_SLT, 4'd1, 1, 4'd5, 0, 0, 0, 6, 0, 32'h300);
      cyc();
      alloc_set(OP_SLTU, 4'd4, 0, 0, 8, 0, 0, 9, 0, 32'h304);
      cdb_set(4'd5, 32'h77);
      cyc();
      alloc_clr();
      cdb_clr();
      chk("t3b_gap", bus.issue_valid, 1'b0);
      cyc();
      chk("t3b_a", bus.issue_valid, 1'b1);
      cyc();
      chk("t3b_c", bus.issue_valid, 1'b1);
      cyc();
      chk("t3b_idle", bus.issue_valid, 1'b0);

      // 4: fill all entries on tag 1
      for (int i = 0; i < 8; i++) begin
         sb.push_back(rec(OP_ADDI, 32'h1234, XLEN'(i), XLEN'(i),
                          32'h400 + XLEN'(4 * i), TAG_W'(i)));
         alloc_set(OP_ADDI, TAG_W'(i), 1, 4'd1, 0, 0, 0, XLEN'(i),
                   XLEN'(i), 32'h400 + XLEN'(4 * i));
         cyc();
      end
      alloc_clr();
      chk("t4_full", bus.alloc_ready, 1'b0);
      alloc_set(OP_ADD, 4'hF, 0, 0, 1, 0, 0, 1, 0, 32'h4FC);
      cyc();
      alloc_clr();
      chk("t4_full2", bus.alloc_ready, 1'b0);
      cdb_set(4'd1, 32'h1234);
      cyc();
      cdb_clr();
      chk("t4_gap", bus.issue_valid, 1'b0);
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("t4_pulse", bus.issue_valid, 1'b1);
         if (k == 0) chk("t4_ardy", bus.alloc_ready, 1'b1);
      end
      cyc();
      chk("t4_end", bus.issue_valid, 1'b0);

      // 5: rs2 bypassed from a CDB in the allocation cycle
      sb.push_back(rec(OP_SLL, 9, 32'hABCD, 32'h5, 32'h500, 4'd7));
      alloc_set(OP_SLL, 4'd7, 0, 0, 9, 1, 4'd4, 0, 32'h5, 32'h500);
      cdb_set(4'd4, 32'hABCD);
      cyc();
      alloc_clr();
      cdb_clr();
      chk("t5_gap", bus.issue_valid, 1'b0);
      cyc();
      chk("t5_issue", bus.issue_valid, 1'b1);
      cyc();

      // 6: flush with alloc, then async reset
      for (int i = 1; i <= 3; i++) begin
         alloc_set(OP_SRL, TAG_W'(i), 1, 4'd6, 0, 0, 0, 0, 0, 32'h600);
         cyc();
      end
      alloc_set(OP_SRA, 4'd9, 0, 0, 1, 0, 0, 2, 0, 32'h610);
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      alloc_clr();
      chk("t6_fvalid", bus.issue_valid, 1'b0);
      chk("t6_ardy", bus.alloc_ready, 1'b1);
      cdb_set(4'd6, 32'h66);
      cyc();
      cdb_clr();
      chk("t6_none0", bus.issue_valid, 1'b0);
      cyc();
      chk("t6_none1", bus.issue_valid, 1'b0);
      cyc();
      chk("t6_none2", bus.issue_valid, 1'b0);

      sb.push_back(rec(OP_LUI, 1, 1, 32'hABC, 32'h700, 4'd8));
      alloc_set(OP_LUI, 4'd8, 0, 0, 1, 0, 0, 1, 32'hABC, 32'h700);
      cyc();
      alloc_clr();
      cyc();
      chk("t6_pre", bus.issue_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rvalid", bus.issue_valid, 1'b0);
      chk("t6_rop", bus.issue_op, '0);
      chk("t6_rimm", bus.issue_imm, '0);
      chk("t6_rardy", bus.alloc_ready, 1'b1);
      cyc();
      rst = 1'b0;
      cyc();
      cyc();
      chk("sb_drained", 160'(sb.size()), 160'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler for the integer ALU in the out-of-order RISC-V core.
- Accepts decoded ALU/branch/jump ops from dispatch and holds each one until its source operands are ready.
- Snoops the common data bus (CDB) for operand values.
- Issues at most one ready op per cycle, oldest first, with operands, immediate, PC and ROB tag to the ALU; ALU results return to the ROB.

Parameters:
- DEPTH, 8, number of station entries (power of 2, ≥2).
- TAG_W, 4, ROB tag width.
- OP_W, 6, opcode width (shared opcode encoding).
- XLEN, 32, data and PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  mispredict flush; synchronous, clears all entries.
- alloc_valid  in  1  dispatch presents a new op.
- alloc_ready  out  1  at least one free entry.
- alloc_op  in  OP_W  opcode.
- alloc_rob_tag  in  TAG_W  destination ROB tag.
- alloc_q1_busy  in  1  rs1 is pending.
- alloc_q1_tag  in  TAG_W  rs1 producer tag.
- alloc_v1  in  XLEN  rs1 value; used only if not busy.
- alloc_q2_busy, alloc_q2_tag, alloc_v2: as above, for rs2.
- alloc_imm  in  XLEN  raw immediate.
- alloc_pc  in  XLEN  instruction PC.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  producing ROB tag.
- cdb_data  in  XLEN  produced value.
- issue_valid  out  1  one-cycle pulse per issued op.
- issue_op  out  OP_W
- issue_v1  out  XLEN
- issue_v2  out  XLEN
- issue_imm  out  XLEN
- issue_pc  out  XLEN
- issue_rob_tag  out  TAG_W

Behaviour:
- Reset: all entries free; issue_valid=0 and every issue_* output=0; alloc_ready=1; age matrix cleared.
- Per-entry state: busy, op, rob_tag, q1_busy/q1_tag/v1, q2_busy/q2_tag/v2, imm, pc. An entry is ready when busy and both q*_busy are 0.
- alloc_ready is a registered-state function: 1 iff any entry is free at the start of the cycle. An issue in the same cycle does not raise it.
- Allocation (alloc_valid & alloc_ready):
  - At the clock edge, the op is written into the lowest-index free entry.
  - The entry is marked younger than every currently busy entry.
- alloc_valid while alloc_ready=0 is ignored; dispatch must hold the op.
- CDB capture:
  - Each busy entry with qN_busy and qN_tag==cdb_tag takes cdb_data into vN and clears qN_busy at the edge.
  - Same-cycle bypass: if an allocating op's qN_tag matches a valid CDB broadcast in that cycle, the entry is written with vN=cdb_data and qN_busy=0.
  - Both operands may capture from one broadcast.
- Selection:
  - Combinational over registered entry state; picks the oldest ready entry using the age matrix older[i][j].
  - At the edge, issue_* registers load that entry, issue_valid=1, and the entry is freed.
  - If no entry is ready, issue_valid=0; issue data holds its last value.
- Latency: an op allocated with both operands ready at edge N has issue_valid high in the cycle after edge N+1. Minimum residency is 2 edges.
- An op woken by the CDB at edge N issues at edge N+1.
- Allocation and issue in the same cycle are both performed. A freed entry becomes allocatable next cycle.
- Flush has top priority: at the edge all busy bits clear, issue_valid=0, and any simultaneous alloc or CDB capture is discarded.
- Reset asserted mid-operation immediately returns all state to reset values, independent of clk.
- Immediate is passed unmodified; sign extension and shifting stay in the ALU.
- No throughput stall from the ALU. The ALU accepts one op per cycle.

Decomposition:
- Shared parameters package: OP_W, XLEN, TAG_W and the opcode constants (LUI..AND), alongside the existing include.
- One sub-module, rs_age_select: DEPTH-wide ready vector plus age matrix in, one-hot grant and any_grant out. It is purely combinational, and the age-matrix update lives in the parent.

Test Plan:
1. Reset, then alloc ADD with v1=5, v2=7, both ready, tag 3 at edge 1 → issue_valid at edge 2 with op=ADD, v1=5, v2=7, rob_tag=3; alloc_ready stays 1.
2. Alloc SUB tag 2 with q1_busy tag 9; then CDB tag 9 data 0x10 two cycles later → no issue before the broadcast; issue at the following edge with v1=0x10.
3. Alloc A (waiting on tag 5), then B (ready), then C (ready); broadcast tag 5 → issue order B, C, A. When A and C are both ready in the same cycle, A goes first.
4. Fill all 8 entries with ops waiting on tag 1 → alloc_ready=0 and a 9th alloc is ignored. One CDB tag 1 → 8 consecutive issue_valid pulses in allocation order, and alloc_ready returns to 1 after the first issue.
5. Alloc with q2_busy tag 4 in the same cycle as CDB tag 4 data 0xABCD → entry captured ready with v2=0xABCD, issue next edge.
6. Three busy entries and flush asserted together with an alloc → zero issues afterwards, alloc_ready=1. Asserting rst mid-cycle forces issue_valid to 0 before the next clock edge.
